// File: rtl/elastic_pipe_pkg.sv
// Shared definitions for the elastic pipeline primitive: CPU payload bundle layout,
// default depth and the flush masks used on branch/jump redirect.
package elastic_pipe_pkg;

  typedef struct packed {
    logic [7:0] instr;
    logic [3:0] pc;
    logic [3:0] ctrl;
  } pipe_payload_t;

  localparam int PAYLOAD_W     = $bits(pipe_payload_t);
  localparam int DEFAULT_DEPTH = 4;

  // Bit i squashes stage i; stage 0 is IF/ID, stage 1 is ID/EX.
  localparam logic [DEFAULT_DEPTH-1:0] FLUSH_NONE     = 4'b0000;
  localparam logic [DEFAULT_DEPTH-1:0] FLUSH_IF_ID    = 4'b0001;
  localparam logic [DEFAULT_DEPTH-1:0] FLUSH_IF_ID_EX = 4'b0011;

endpackage

// File: rtl/elastic_stage.sv
// One elastic register stage: holds a valid flag and payload, accepts when empty,
// flushed or draining, and releases its entry when the next stage is ready.
module elastic_stage
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             flush,
  input  logic             rdy,
  input  logic             dn_ready,
  output logic             ev,
  output logic             v_q,
  output logic             v_nxt,
  output logic [WIDTH-1:0] d_q
);

  logic accept;
  logic leave;

  assign ev     = v_q & ~flush;
  assign accept = up_valid & rdy;
  assign leave  = ev & dn_ready;

  // An arriving payload wins over a flush of the entry it replaces.
  always_comb begin
    v_nxt = ev;
    if (accept)     v_nxt = 1'b1;
    else if (leave) v_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_nxt;
      if (accept) d_q <= up_data;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage elastic pipeline with valid/ready back-pressure, bubble collapse,
// per-stage flush and a registered occupancy count.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int WIDTH = PAYLOAD_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic [DEPTH-1:0] flush,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] ev;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] dn_ready;
  logic [WIDTH-1:0] up_data [DEPTH];
  logic [WIDTH-1:0] d       [DEPTH];

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] bits);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(bits[i]);
    return cnt;
  endfunction

  // Ready ripples from the output back toward the input; an empty or flushed
  // stage is always ready, which is what collapses bubbles under stall.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = ~ev[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) rdy[i] = ~ev[i] | rdy[i+1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_valid[i] = in_valid;
      assign up_data[i]  = in_data;
    end else begin : g_link
      assign up_valid[i] = ev[i-1];
      assign up_data[i]  = d[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_ready[i] = out_ready;
    end else begin : g_mid
      assign dn_ready[i] = rdy[i+1];
    end

    elastic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid[i]),
      .up_data  (up_data[i]),
      .flush    (flush[i]),
      .rdy      (rdy[i]),
      .dn_ready (dn_ready[i]),
      .ev       (ev[i]),
      .v_q      (v[i]),
      .v_nxt    (v_nxt[i]),
      .d_q      (d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occupancy <= '0;
    else        occupancy <= popcount(v_nxt);
  end

  assign in_ready    = rdy[0];
  assign out_valid   = ev[DEPTH-1];
  assign out_data    = d[DEPTH-1];
  assign stage_valid = v;

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe (WIDTH=16, DEPTH=4): accepted inputs are queued,
// delivered outputs are popped and compared in order.
module tb_elastic_pipe;
  import elastic_pipe_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] occupancy;

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .flush       (flush),
    .stage_valid (stage_valid),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] sbq [$];
  logic             got_out;
  logic [WIDTH-1:0] out_act;
  logic [WIDTH-1:0] out_exp;
  logic             s_in_ready;
  logic             s_out_valid;
  logic [WIDTH-1:0] s_out_data;
  logic [CNT_W-1:0] s_occ;
  logic [DEPTH-1:0] s_sv;

  // Samples the cycle at the falling edge, records handshakes, then advances one edge.
  task automatic tick();
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_occ       = occupancy;
    s_sv        = stage_valid;
    got_out     = 1'b0;
    if (in_valid && in_ready) sbq.push_back(in_data);
    if (out_valid && out_ready) begin
      got_out = 1'b1;
      out_act = out_data;
      if (sbq.size() > 0) out_exp = sbq.pop_front();
      else                out_exp = 'x;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (occupancy !== 3'd0) begin
      miscompares++; $display("FAIL reset_occ_held: got %0d want 0", occupancy);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", s_in_ready); end
    vectors++;
    if (s_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", s_out_valid); end
    vectors++;
    if (s_occ !== 3'd0) begin miscompares++; $display("FAIL reset_occ: got %0d want 0", s_occ); end
    vectors++;
    if (s_sv !== 4'b0000) begin miscompares++; $display("FAIL reset_stage_valid: got %b want 0000", s_sv); end
    vectors++;
    if (got_out !== 1'b0) begin miscompares++; $display("FAIL reset_empty_out: got %b want 0", got_out); end
  endtask

  task automatic test_stream();
    int n_out = 0;
    int first_vld = -1;
    out_ready = 1'b1; flush = '0;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 10);
      in_data  = 16'h1000 + 16'(c);
      tick();
      if (first_vld < 0 && s_out_valid) first_vld = c;
      if (c < 10) begin
        vectors++;
        if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready c=%0d: got %b want 1", c, s_in_ready); end
      end
      if (c >= 4 && c <= 10) begin
        vectors++;
        if (s_occ !== 3'd4) begin miscompares++; $display("FAIL stream_occ c=%0d: got %0d want 4", c, s_occ); end
      end
      if (got_out) begin
        vectors++; n_out++;
        if (out_act !== out_exp) begin miscompares++; $display("FAIL stream_data: got %h want %h", out_act, out_exp); end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (first_vld != 4) begin miscompares++; $display("FAIL stream_latency: got %0d want 4", first_vld); end
    vectors++;
    if (n_out != 10) begin miscompares++; $display("FAIL stream_count: got %0d want 10", n_out); end
  endtask

  task automatic test_back_pressure();
    int n_out = 0;
    out_ready = 1'b0; flush = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 16'h00A1 + 16'(k);
      tick();
    end
    in_valid = 1'b1; in_data = 16'h00EE;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (s_in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b want 0", s_in_ready); end
      vectors++;
      if (s_occ !== 3'd4) begin miscompares++; $display("FAIL bp_occ: got %0d want 4", s_occ); end
      vectors++;
      if (s_out_valid !== 1'b1 || s_out_data !== 16'h00A1) begin
        miscompares++; $display("FAIL bp_hold: got %b/%h want 1/00a1", s_out_valid, s_out_data);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 12 && n_out < 4; c++) begin
      tick();
      if (got_out) begin
        vectors++; n_out++;
        if (out_act !== out_exp) begin miscompares++; $display("FAIL bp_drain: got %h want %h", out_act, out_exp); end
      end
    end
    vectors++;
    if (n_out != 4 || sbq.size() != 0) begin
      miscompares++; $display("FAIL bp_count: got %0d left %0d want 4 left 0", n_out, sbq.size());
    end
  endtask

  task automatic test_bubble();
    int n_out = 0;
    out_ready = 1'b0; flush = '0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0 || c == 3);
      in_data  = (c == 0) ? 16'h00B1 : 16'h00B2;
      tick();
      if (c >= 6) begin
        vectors++;
        if (s_sv !== 4'b1100) begin miscompares++; $display("FAIL bubble_sv: got %b want 1100", s_sv); end
        vectors++;
        if (s_occ !== 3'd2) begin miscompares++; $display("FAIL bubble_occ: got %0d want 2", s_occ); end
        vectors++;
        if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL bubble_in_ready: got %b want 1", s_in_ready); end
        vectors++;
        if (s_out_data !== 16'h00B1) begin miscompares++; $display("FAIL bubble_head: got %h want 00b1", s_out_data); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && n_out < 2; c++) begin
      tick();
      if (got_out) begin
        vectors++; n_out++;
        if (out_act !== out_exp) begin miscompares++; $display("FAIL bubble_drain: got %h want %h", out_act, out_exp); end
      end
    end
    vectors++;
    if (n_out != 2) begin miscompares++; $display("FAIL bubble_count: got %0d want 2", n_out); end
  endtask

  task automatic test_flush();
    int n_out = 0;
    out_ready = 1'b0; flush = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 16'h00C1 + 16'(k);
      tick();
    end
    // 0xC3/0xC4 are squashed; 0xC5 still enters stage 0 on the same edge.
    sbq.delete(3);
    sbq.delete(2);
    flush = FLUSH_IF_ID_EX; in_valid = 1'b1; in_data = 16'h00C5;
    tick();
    vectors++;
    if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready: got %b want 1", s_in_ready); end
    flush = '0; in_valid = 1'b0;
    tick();
    vectors++;
    if (s_sv !== 4'b1101) begin miscompares++; $display("FAIL flush_sv: got %b want 1101", s_sv); end
    vectors++;
    if (s_occ !== 3'd3) begin miscompares++; $display("FAIL flush_occ: got %0d want 3", s_occ); end
    out_ready = 1'b1;
    for (int c = 0; c < 12 && n_out < 3; c++) begin
      tick();
      if (got_out) begin
        vectors++; n_out++;
        if (out_act !== out_exp) begin miscompares++; $display("FAIL flush_drain: got %h want %h", out_act, out_exp); end
      end
    end
    vectors++;
    if (n_out != 3 || sbq.size() != 0) begin
      miscompares++; $display("FAIL flush_count: got %0d left %0d want 3 left 0", n_out, sbq.size());
    end
  endtask

  task automatic test_flush_stall();
    int n_out = 0;
    logic [WIDTH-1:0] dropped;
    out_ready = 1'b0; flush = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 16'h00D1 + 16'(k);
      tick();
    end
    in_valid = 1'b0; flush = 4'b1000;
    dropped = sbq.pop_front();
    tick();
    vectors++;
    if (s_out_valid !== 1'b0) begin miscompares++; $display("FAIL fstall_out_valid: got %b want 0", s_out_valid); end
    vectors++;
    if (s_in_ready !== 1'b1) begin miscompares++; $display("FAIL fstall_in_ready: got %b want 1", s_in_ready); end
    flush = '0;
    tick();
    vectors++;
    if (s_sv !== 4'b1110) begin miscompares++; $display("FAIL fstall_sv: got %b want 1110", s_sv); end
    vectors++;
    if (s_occ !== 3'd3) begin miscompares++; $display("FAIL fstall_occ: got %0d want 3", s_occ); end
    vectors++;
    if (s_out_valid !== 1'b1 || s_out_data !== 16'h00D2) begin
      miscompares++; $display("FAIL fstall_shift: got %b/%h want 1/00d2 (dropped %h)", s_out_valid, s_out_data, dropped);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (got_out) begin
        vectors++; n_out++;
        if (out_act !== out_exp) begin miscompares++; $display("FAIL fstall_drain: got %h want %h", out_act, out_exp); end
      end
    end
    vectors++;
    if (n_out != 3) begin miscompares++; $display("FAIL fstall_count: got %0d want 3", n_out); end
  endtask

  task automatic test_async_reset();
    int n_out = 0;
    out_ready = 1'b0; flush = '0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 16'h00E1 + 16'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    #2;
    vectors++;
    if (out_valid !== 1'b1 || occupancy !== 3'd3) begin
      miscompares++; $display("FAIL areset_pre: got %b/%0d want 1/3", out_valid, occupancy);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (stage_valid !== 4'b0000) begin miscompares++; $display("FAIL areset_sv: got %b want 0000", stage_valid); end
    vectors++;
    if (occupancy !== 3'd0) begin miscompares++; $display("FAIL areset_occ: got %0d want 0", occupancy); end
    sbq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h00F1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (got_out) begin
        vectors++; n_out++;
        if (out_act !== out_exp) begin miscompares++; $display("FAIL areset_recover: got %h want %h", out_act, out_exp); end
      end
    end
    vectors++;
    if (n_out != 1) begin miscompares++; $display("FAIL areset_count: got %0d want 1", n_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_bubble();
    test_flush();
    test_flush_stall();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elastic_pipe.md
Name: elastic_pipe

Overview:
- Parametrised N-stage elastic pipeline register chain with valid/ready handshake, bubble collapse, per-stage flush and an occupancy counter.
- Replaces the fixed, always-enabled inter-stage flop banks in the CPU with a single reusable primitive.
- Lets the CPU stall (back-pressure) and squash younger stages on branch/jump redirect, which the existing pipeline cannot do.

Parameters:
- WIDTH, 16, payload bits per stage (instr/pc/control bundle); must be >= 1.
- DEPTH, 4, number of register stages; must be >= 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a payload.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  stage 0 can accept this cycle.
- out_valid  output  1  last stage holds a live payload.
- out_data  output  WIDTH  last-stage payload.
- out_ready  input  1  downstream consumes this cycle.
- flush  input  DEPTH  per-stage kill; bit i squashes stage i.
- stage_valid  output  DEPTH  live-entry flag per stage (for hazard logic).
- occupancy  output  CNT_W  registered count of live stages.

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits, all stage data, and occupancy go to 0. in_ready=1 and out_valid=0 after reset release.
- Per-stage state: v[i] and d[i]. Stage 0 is nearest the input; stage DEPTH-1 drives out_valid/out_data.
- Effective valid: ev[i] = v[i] & ~flush[i]. A flushed stage never offers its payload downstream in that cycle.
- Ready chain (combinational, from output back to input):
  - rdy[DEPTH-1] = ~ev[DEPTH-1] | out_ready.
  - rdy[i] = ~ev[i] | rdy[i+1].
  - in_ready = rdy[0].
- Bubble collapse: an empty or flushed stage always accepts, even while downstream is stalled.
- Transfer into stage i (upstream for stage 0 is in_valid/in_data) occurs when upstream's effective valid and rdy[i] are both 1.
  - On transfer: d[i] <= upstream data, v[i] <= 1.
  - Otherwise, if stage i's payload leaves (ev[i] & rdy[i+1], or ev[i] & out_ready for the last stage), v[i] <= 0.
  - Otherwise, v[i] <= ev[i]. This holds a stalled entry, or kills it if flushed.
- d[i] loads only on transfer. It does not clear on flush or drain.
- Flush in the same cycle as an incoming transfer to the same stage: the incoming payload is accepted. flush[i] kills only the entry currently in stage i, not the one arriving.
- Flush plus downstream stall: the flushed entry disappears and the slot accepts new data the same cycle.
- out_valid = ev[DEPTH-1]; out_data = d[DEPTH-1].
- Latency: a payload accepted at edge k into an empty, unstalled pipe appears with out_valid=1 after edge k+DEPTH-1. That is DEPTH cycles after in_valid is presented.
- Throughput: one payload per cycle with out_ready held high.
- stage_valid = v (raw registered flags, pre-flush).
- occupancy: registered, equal to popcount of v after each edge. Range 0..DEPTH; no wrap is possible.
- Full: all v=1, no flush, out_ready=0 → in_ready=0, state frozen.
- Empty: out_valid=0; out_ready is ignored.
- DEPTH=1: the block degenerates to a single elastic register with the same rules.
- Reset asserted mid-operation: all entries are discarded immediately and asynchronously. There is no partial drain.

Decomposition:
- Shared package: pipeline payload struct/width constants (CPU bundle widths, default DEPTH=4) and flush-mask encodings (e.g. "kill IF/ID", "kill IF/ID/EX").
- One sub-module, elastic_stage: a single stage (v/d registers, ev, accept/leave logic). It is generated DEPTH times with a ready-chain wire between stages.
- The occupancy counter stays in the top level.

Test Plan:
- Reset then stream: in_valid=1, data 0x1000..0x1009, out_ready=1, DEPTH=4 → first out_valid 4 cycles after the first in_valid, then 10 consecutive outputs 0x1000..0x1009 in order, in_ready never drops, occupancy steady at 4.
- Back-pressure: fill with 0xA1..0xA4, hold out_ready=0 → in_ready=0, occupancy=4, out_data=0xA1 stable. Release → drains 0xA1..0xA4 with no loss or duplication.
- Bubble collapse: insert 0xB1, idle 2 cycles, insert 0xB2, out_ready=0 → both entries pack into stages 3 and 2, occupancy=2, in_ready=1.
- Flush: pipe holds 0xC1..0xC4 (stage3..0), flush=4'b0011 with in_valid=1 data 0xC5 → 0xC3/0xC4 vanish, 0xC5 enters stage 0, occupancy=3. Outputs continue 0xC1, 0xC2, 0xC5.
- Flush while stalled: full pipe, out_ready=0, flush=4'b1000 → out_valid drops that cycle; the next edge shifts stage 2 into stage 3. No entry ever reappears.
- Async reset mid-stream: drop rst_n between edges with 3 entries live → out_valid=0, stage_valid=0, occupancy=0 immediately, without waiting for a clock edge.
